reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Single-clock reset sequencer for one clock domain. Holds a set of active-high stage resets
//  asserted until the PLL lock is stable for LOCK_FILTER cycles. Then releases the stages in
//  ascending order, one every STAGE_GAP cycles. Re-enters reset on lock loss or on a software
//  reset request. Consumers are the per-domain resets of the FM synth core, the DAC and the
//  bus bridge.
// PARAMETERS
//  N_STAGES     3    number of staged reset outputs (>=1)
//  LOCK_FILTER  256  consecutive synced-lock-high cycles required before release (>=2)
//  STAGE_GAP    16   cycles between successive stage releases (>=1)
//  SW_RST_MIN   32   minimum HOLD duration after lock loss / sw request (>=1)
// PORTS
//  clk          in   1         domain clock
//  arst_n       in   1         asynchronous, active-low reset (async assert; deassertion pre-synchronised to clk)
//  pll_locked   in   1         PLL lock, asynchronous to clk
//  sw_rst_req   in   1         clk-synchronous software reset request, sampled every cycle
//  rst_out      out  N_STAGES  active-high stage resets; bit 0 is released first
//  rst_done     out  1         1 when all stages are released (state RUN)
//  state_o      out  2         debug: current FSM state encoding
// BEHAVIOUR
//  Reset (arst_n=0, immediate):
//   - rst_out = all ones, rst_done = 0, state = WAIT_LOCK (00).
//   - counter = 0, stage index = 0, both lock sync flops = 0.
//  Lock sync: 2-flop synchroniser -> lock_s. No logic uses pll_locked directly.
//  Edge numbering: edge 1 is the first rising clk edge after arst_n deasserts. With
//   pll_locked=1 throughout, lock_s is 1 after edge 2.
//  WAIT_LOCK (00):
//   - rst_out = all ones. cnt increments on each edge with lock_s=1; lock_s=0 clears cnt to 0.
//   - At the edge where lock_s=1 and cnt==LOCK_FILTER-1: go to RELEASE, cnt=0, idx=0.
//   - sw_rst_req is ignored.
//  RELEASE (01):
//   - cnt increments every edge.
//   - At cnt==STAGE_GAP-1: clear rst_out[idx], idx++, cnt=0.
//   - When the cleared bit is N_STAGES-1: go to RUN on that same edge, so rst_done rises on
//     the edge at which rst_out[N_STAGES-1] falls.
//   - Release timing: rst_out[k] falls at edge 2+LOCK_FILTER+(k+1)*STAGE_GAP.
//  RUN (10): rst_out = 0, rst_done = 1. Stays in RUN until lock_s=0 or sw_rst_req=1.
//  HOLD (11):
//   - Entered from RELEASE or RUN on lock_s=0 or sw_rst_req=1.
//   - On the entry edge: rst_out = all ones, rst_done = 0, cnt = 0.
//   - Stays in HOLD for SW_RST_MIN edges, regardless of lock and of further requests, then
//     goes to WAIT_LOCK with cnt = 0.
//  Simultaneous events:
//   - Lock loss and sw_rst_req on the same edge cause a single HOLD entry.
//   - In RELEASE, an abort takes priority over a stage release on the same edge.
//  Reset mid-operation: arst_n=0 in any state forces the reset values asynchronously.
//  Registers:
//   - All outputs are registered; no combinational path from any input to any output.
//   - rst_out bits are monotonic during RELEASE: once cleared, a bit stays 0 until HOLD or arst.
//  Counter width: clog2(max(LOCK_FILTER, STAGE_GAP, SW_RST_MIN)) + 1; the counter never wraps.
// TESTING (bench params: N_STAGES=3, LOCK_FILTER=8, STAGE_GAP=4, SW_RST_MIN=5)
//  1. arst_n release with pll_locked=1 -> rst_out[0] falls at edge 14, [1] at edge 18,
//     [2] and rst_done at edge 22, state_o=10.
//  2. pll_locked=1 with a single-cycle 0 glitch during WAIT_LOCK -> filter restarts; release
//     is delayed by the full LOCK_FILTER time measured from the glitch.
//  3. In RUN, pulse sw_rst_req for 1 cycle -> next edge rst_out=111, rst_done=0, state 11;
//     5 edges later state 00; 8 edges after that rst_out[0] sequence restarts.
//  4. Drop pll_locked in RELEASE after rst_out=110 -> rst_out=111 on the edge lock_s is seen
//     low; no partial release remains.
//  5. Lock loss and sw_rst_req on the same edge in RUN -> exactly one HOLD of 5 cycles.
//  6. arst_n pulsed low mid-RELEASE (between clk edges) -> rst_out=111, rst_done=0, state 00
//     immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer for one clock domain.
// Filters PLL lock, releases stage resets in order, re-enters reset on loss/request.
module reset_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int LOCK_FILTER = 256,
    parameter int STAGE_GAP   = 16,
    parameter int SW_RST_MIN  = 32
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                pll_locked,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                rst_done,
    output logic [1:0]          state_o
);

    localparam int MAX_AB = (LOCK_FILTER > STAGE_GAP) ? LOCK_FILTER : STAGE_GAP;
    localparam int MAX_C  = (MAX_AB > SW_RST_MIN) ? MAX_AB : SW_RST_MIN;
    localparam int CNT_W  = $clog2(MAX_C) + 1;
    localparam int IDX_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_RST_MIN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        RELEASE   = 2'b01,
        RUN       = 2'b10,
        HOLD      = 2'b11
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                sync1_q;
    logic                lock_s;
    logic                abort;
    logic                stage_tick;
    logic [N_STAGES-1:0] rst_d;
    logic                done_d;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lock_s  <= sync1_q;
        end
    end

    assign abort      = !lock_s || sw_rst_req;
    assign stage_tick = (cnt_q == GAP_LAST);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_out  <= rst_d;
            rst_done <= done_d;
        end
    end

    // Next state, counter and stage index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (abort) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (stage_tick) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Next registered outputs; released bits only ever clear while in RELEASE
    always_comb begin
        rst_d  = '1;
        done_d = 1'b0;
        unique case (state_d)
            WAIT_LOCK: rst_d = '1;
            HOLD:      rst_d = '1;
            RUN: begin
                rst_d  = '0;
                done_d = 1'b1;
            end
            RELEASE: begin
                rst_d = rst_out;
                if (state_q == RELEASE && stage_tick) begin
                    for (int i = 0; i < N_STAGES; i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                end
            end
            default: rst_d = '1;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Directed scenarios followed by randomized lock/request/reset traffic.
module tb_reset_sequencer;

    localparam int NS  = 3;
    localparam int LF  = 8;
    localparam int GAP = 4;
    localparam int MIN = 5;

    localparam int P_WAIT = 0;
    localparam int P_REL  = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          pll_locked;
    logic          sw_rst_req;
    logic [NS-1:0] rst_out;
    logic          rst_done;
    logic [1:0]    state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase plus elapsed-time counters
    bit m_s1, m_s2;
    int m_ph, m_run, m_rel, m_hold;

    reset_sequencer #(
        .N_STAGES   (NS),
        .LOCK_FILTER(LF),
        .STAGE_GAP  (GAP),
        .SW_RST_MIN (MIN)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .rst_out   (rst_out),
        .rst_done  (rst_done),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] exp_rst();
        logic [NS-1:0] v;
        for (int k = 0; k < NS; k++) begin
            if (m_ph == P_REL) v[k] = (m_rel < (k + 1) * GAP);
            else               v[k] = (m_ph != P_RUN);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_ph   = P_WAIT;
        m_run  = 0;
        m_rel  = 0;
        m_hold = 0;
    endtask

    task automatic model_edge(input bit pll, input bit sw);
        bit ls;
        bit ab;
        ls = m_s2;
        ab = !ls || sw;
        case (m_ph)
            P_WAIT: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == LF) begin
                    m_ph  = P_REL;
                    m_rel = 0;
                end
            end
            P_REL: begin
                if (ab) begin
                    m_ph   = P_HOLD;
                    m_hold = 0;
                end else begin
                    m_rel++;
                    if (m_rel == NS * GAP) m_ph = P_RUN;
                end
            end
            P_RUN: begin
                if (ab) begin
                    m_ph   = P_HOLD;
                    m_hold = 0;
                end
            end
            default: begin
                m_hold++;
                if (m_hold == MIN) begin
                    m_ph  = P_WAIT;
                    m_run = 0;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = pll;
    endtask

    task automatic check_all();
        logic [1:0] ph;
        ph = 2'(m_ph);
        check("rst_out", rst_out, exp_rst());
        check("rst_done", rst_done, m_ph == P_RUN);
        check("state_o", state_o, ph);
    endtask

    // One clock: drive at negedge, model and check just after posedge
    task automatic cycle(input bit pll, input bit sw);
        pll_locked = pll;
        sw_rst_req = sw;
        @(posedge clk);
        model_edge(pll, sw);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Async reset pulse landing between clock edges
    task automatic do_arst();
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check("arst_rst_out", rst_out, 3'b111);
        check("arst_done", rst_done, 1'b0);
        check("arst_state", state_o, 2'b00);
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit p;
        bit s;
        arst_n     = 1'b0;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        arst_n = 1'b1;

        // Clean lock: stages fall at edges 14, 18, 22
        for (int e = 1; e <= 22; e++) begin
            cycle(1'b1, 1'b0);
            if (e == 13) check("t1_e13", rst_out, 3'b111);
            if (e == 14) check("t1_e14", rst_out, 3'b110);
            if (e == 17) check("t1_e17", rst_out, 3'b110);
            if (e == 18) check("t1_e18", rst_out, 3'b100);
            if (e == 21) check("t1_e21_done", rst_done, 1'b0);
            if (e == 22) begin
                check("t1_e22", rst_out, 3'b000);
                check("t1_e22_done", rst_done, 1'b1);
                check("t1_e22_state", state_o, 2'b10);
            end
        end

        // Software request pulse from RUN
        cycle(1'b1, 1'b1);
        check("t3_hold", state_o, 2'b11);
        check("t3_hold_rst", rst_out, 3'b111);
        repeat (4) cycle(1'b1, 1'b0);
        check("t3_hold4", state_o, 2'b11);
        cycle(1'b1, 1'b0);
        check("t3_wait", state_o, 2'b00);
        repeat (8) cycle(1'b1, 1'b0);
        check("t3_rel", state_o, 2'b01);
        repeat (4) cycle(1'b1, 1'b0);
        check("t3_bit0", rst_out, 3'b110);

        // Lock loss during RELEASE after the first stage
        cycle(1'b0, 1'b0);
        check("t4_a0", rst_out, 3'b110);
        cycle(1'b0, 1'b0);
        check("t4_a1", rst_out, 3'b110);
        cycle(1'b0, 1'b0);
        check("t4_a2", rst_out, 3'b111);
        check("t4_a2_state", state_o, 2'b11);
        repeat (10) cycle(1'b0, 1'b0);
        repeat (30) cycle(1'b1, 1'b0);
        check("t4_run", state_o, 2'b10);

        // Lock loss and request seen on the same edge
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("t5_hold", state_o, 2'b11);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0);
            check("t5_hold_n", state_o, 2'b11);
        end
        cycle(1'b1, 1'b0);
        check("t5_wait", state_o, 2'b00);
        repeat (3) cycle(1'b1, 1'b0);
        check("t5_still_wait", state_o, 2'b00);

        // Glitch in WAIT_LOCK restarts the filter
        do_arst();
        for (int e = 1; e <= 20; e++) begin
            cycle(e != 6, 1'b0);
            if (e == 10) check("t2_e10_state", state_o, 2'b00);
            if (e == 19) check("t2_e19", rst_out, 3'b111);
            if (e == 20) check("t2_e20", rst_out, 3'b110);
        end

        // Async reset in the middle of RELEASE
        check("t6_pre", state_o, 2'b01);
        do_arst();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_arst();
            end else begin
                p = ($urandom_range(0, 99) >= 3);
                s = ($urandom_range(0, 199) == 0);
                cycle(p, s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
